former_burst_sequencer: RTL
===========================

// Module: former_burst_sequencer
// PURPOSE
//  Sequences data_former over multi-word bursts.
//  - Per word: pulses next_count STEP times, then issues one start_send.
//  - Waits for the valid&ready transfer, then inserts an inter-word gap.
//  - Counts words sent and reports completion; sits between the command source and data_former.
// PARAMETERS
//  LEN_W          8    width of cmd_len; burst = cmd_len+1 words (1..2**LEN_W)
//  STEP_W         4    width of cmd_step; next_count pulses issued before each word
//  GAP_CYCLES     2    idle cycles between words (0 = no gap)
//  TIMEOUT_CYCLES 255  WAIT_XFER cycles before abort (SEQ_TIMEOUT_EN only)
// PORTS
//  clk_100            in   1         system clock, all logic on rising edge
//  a_rst_n            in   1         asynchronous reset, active-low
//  s_rst              in   1         synchronous clear, active-high, same effect as a_rst_n
//  cmd_valid          in   1         burst command offered
//  cmd_ready          out  1         sequencer can accept command (IDLE only)
//  cmd_len            in   LEN_W     words in burst minus one
//  cmd_step           in   STEP_W    counter advances per word
//  former_next_count  out  1         to data_former.next_count
//  former_start_send  out  1         to data_former.start_send
//  former_valid       in   1         monitors data_former.valid
//  sink_ready         in   1         monitors ready driven into data_former
//  busy               out  1         high in any state except IDLE
//  done               out  1         one-cycle pulse at burst end (normal or abort)
//  words_sent         out  LEN_W+1   words transferred in current/last burst
//  timeout_err        out  1         sticky abort flag
// BEHAVIOUR
//  Reset (a_rst_n=0 or s_rst=1):
//  - FSM to IDLE; every output 0 except cmd_ready=1.
//  - Counters cleared; timeout_err cleared.
//  - Reset mid-burst aborts immediately; no done pulse.
//  FSM states: IDLE, STEP, LAUNCH, WAIT_XFER, GAP, DONE.
//  - IDLE: cmd_ready=1. On cmd_valid:
//    - latch cmd_len, cmd_step; clear words_sent and timeout_err
//    - go to STEP if step!=0, else LAUNCH. Accept to first output is 1 cycle.
//  - STEP: former_next_count=1 for exactly step consecutive cycles, then LAUNCH.
//  - LAUNCH: former_start_send=1 for exactly one cycle, then WAIT_XFER.
//  - WAIT_XFER: transfer = former_valid & sink_ready in the same cycle.
//    - On transfer: words_sent+1 in that clock.
//    - If words_sent reaches len+1 -> DONE.
//    - Else -> GAP, or STEP/LAUNCH when GAP_CYCLES=0.
//  - GAP: GAP_CYCLES cycles with all strobes low, then STEP (LAUNCH if step=0).
//  - DONE: done=1 for one cycle, then IDLE. cmd_ready=0 here; back-to-back commands need >=1 IDLE cycle.
//  - former_next_count and former_start_send are never high in the same cycle.
//  - Valid without ready holds WAIT_XFER; no re-launch.
//  - cmd_* ignored while busy. words_sent holds its value after DONE until next accept.
//  - cmd_len=max gives 2**LEN_W words; the internal compare is LEN_W+1 bits wide, with no wrap.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//  - A timer counts WAIT_XFER cycles and restarts on every entry to WAIT_XFER.
//  - At TIMEOUT_CYCLES with no transfer: timeout_err=1 (sticky), go to DONE (done pulses).
//  - Remaining words are dropped.
//  - A transfer in the terminal cycle wins: counted, no error.
//  SEQ_TIMEOUT_EN undefined:
//  - No timer; WAIT_XFER waits indefinitely.
//  - timeout_err tied to 0.
// TESTING
//  1. cmd_len=0, cmd_step=1, ready high
//     -> 1 next_count cycle, 1 start_send cycle, words_sent=1, done pulse, cmd_ready back to 1.
//  2. cmd_len=3, cmd_step=2, GAP_CYCLES=2
//     -> per word: 2 next_count cycles then 1 start_send; 2-cycle gaps; words_sent=4; exactly 4 start_send pulses.
//  3. cmd_step=0, cmd_len=1
//     -> no next_count pulses; start_send one cycle after accept; words_sent=2.
//  4. sink_ready low 20 cycles during WAIT_XFER, then high
//     -> stays in WAIT_XFER, no extra start_send, word counted once.
//  5. SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, sink_ready held low
//     -> after 8 cycles: timeout_err=1, done pulse, words_sent=0, IDLE.
//     Without the macro: busy stays 1.
//  6. a_rst_n low, then s_rst high, each mid-burst in STEP
//     -> next cycle all strobes 0, busy=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/former_burst_sequencer.sv
// Burst sequencer driving data_former: per word, STEP next_count pulses, one start_send,
// wait for the valid&ready transfer, then an inter-word gap. Optional WAIT_XFER abort via SEQ_TIMEOUT_EN.
module former_burst_sequencer #(
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned STEP_W         = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_100,
  input  logic              a_rst_n,
  input  logic              s_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [STEP_W-1:0] cmd_step,
  output logic              former_next_count,
  output logic              former_start_send,
  input  logic              former_valid,
  input  logic              sink_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W:0]    words_sent,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_LAUNCH,
    S_WAIT_XFER,
    S_GAP,
    S_DONE
  } state_t;

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (TIMEOUT_CYCLES == 0 || STEP_W == 0 || LEN_W == 0) begin : g_param_check
    $error("former_burst_sequencer: LEN_W, STEP_W and TIMEOUT_CYCLES must be non-zero");
  end

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [LEN_W:0]      words_q, words_d;
  logic                xfer;
  logic                last_word;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                terr_q, terr_d;
`endif

  assign xfer = former_valid & sink_ready;
  // Compare is one bit wider than cmd_len so a max-length burst of 2**LEN_W words does not wrap.
  assign last_word = (words_q + (LEN_W+1)'(1)) == ({1'b0, len_q} + (LEN_W+1)'(1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    step_d     = step_q;
    step_cnt_d = step_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    words_d    = words_q;
`ifdef SEQ_TIMEOUT_EN
    timer_d    = timer_q;
    terr_d     = terr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d      = cmd_len;
          step_d     = cmd_step;
          words_d    = '0;
          step_cnt_d = '0;
`ifdef SEQ_TIMEOUT_EN
          terr_d     = 1'b0;
`endif
          state_d    = (cmd_step != '0) ? S_STEP : S_LAUNCH;
        end
      end
      S_STEP: begin
        if (step_cnt_q == step_q - STEP_W'(1)) begin
          step_cnt_d = '0;
          state_d    = S_LAUNCH;
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      S_LAUNCH: begin
`ifdef SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = S_WAIT_XFER;
      end
      S_WAIT_XFER: begin
        if (xfer) begin
          words_d = words_q + (LEN_W+1)'(1);
          if (last_word) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES != 0) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            state_d = (step_q != '0) ? S_STEP : S_LAUNCH;
          end
`ifdef SEQ_TIMEOUT_EN
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
`endif
        end
      end
      S_GAP: begin
        if (32'(gap_cnt_q) == GAP_CYCLES - 1) begin
          state_d = (step_q != '0) ? S_STEP : S_LAUNCH;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // s_rst is a synchronous clear with the same effect as the asynchronous reset.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      step_q     <= '0;
      step_cnt_q <= '0;
      gap_cnt_q  <= '0;
      words_q    <= '0;
`ifdef SEQ_TIMEOUT_EN
      timer_q    <= '0;
      terr_q     <= 1'b0;
`endif
    end else if (s_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      step_q     <= '0;
      step_cnt_q <= '0;
      gap_cnt_q  <= '0;
      words_q    <= '0;
`ifdef SEQ_TIMEOUT_EN
      timer_q    <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      words_q    <= words_d;
`ifdef SEQ_TIMEOUT_EN
      timer_q    <= timer_d;
      terr_q     <= terr_d;
`endif
    end
  end

  assign cmd_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign former_next_count = (state_q == S_STEP);
  assign former_start_send = (state_q == S_LAUNCH);
  assign done              = (state_q == S_DONE);
  assign words_sent        = words_q;
`ifdef SEQ_TIMEOUT_EN
  assign timeout_err       = terr_q;
`else
  assign timeout_err       = 1'b0;
`endif

endmodule
